// File: rtl/full_add_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB slice first,
// with a registered carry between slices and a registered result on DONE.
//
// state  | meaning
// S_IDLE | waiting for start; result outputs hold the last value
// S_RUN  | one slice added per cycle, N cycles total
// S_DONE | one-cycle result pulse; start here chains straight into RUN
module full_add_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;

    logic             accept;
    logic             last;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             msb_cin;

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (cnt_q == '0);

    // Operands shift right each cycle so the active slice is always the low CHUNK bits.
    assign slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + (CHUNK+1)'(carry_q);
    assign acc_next  = (acc_q >> CHUNK)
                     | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    // Carry into the top bit recovered from the top bit's operands and its sum bit.
    assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_sum[CHUNK-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + !cin, so invert b and the carry-in up front.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= CW'(N - 1);
            acc_q   <= '0;
        end else if (state_q == S_RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= slice_sum[CHUNK];
            acc_q   <= acc_next;
            if (!last) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (last) begin
                sum  <= acc_next;
                cout <= slice_sum[CHUNK];
                ovf  <= msb_cin ^ slice_sum[CHUNK];
            end
        end
    end

endmodule
